// File: rtl/button_counter.sv
// button_counter: two raw push-buttons are synchronized, debounced by a
// per-button FSM into single-cycle press pulses, and those pulses drive a
// WIDTH-bit up/down counter.
module button_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned WIDTH           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic [WIDTH-1:0] count_out
);

    localparam int unsigned NUM_BTN = 2;
    localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } deb_state_e;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_pulse;

    // Index 0 is the up button, index 1 the down button.
    assign btn_raw = {btn_down, btn_up};

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        logic             sync1_q;
        logic             sync2_q;
        deb_state_e       state_q;
        deb_state_e       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             pulse_q;
        logic             pulse_d;

        // Two-flop synchronizer; only the second stage is consumed.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= btn_raw[gi];
                sync2_q <= sync1_q;
            end
        end

        // Debounce FSM state, window counter and registered press pulse.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        // Next-state logic: a level change is accepted only after a full
        // window of stable samples; any opposite sample aborts the window.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        state_d = DEB_PRESS;
                        cnt_d   = '0;
                    end
                end
                DEB_PRESS: begin
                    if (!sync2_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!sync2_q) begin
                        state_d = DEB_RELEASE;
                        cnt_d   = '0;
                    end
                end
                DEB_RELEASE: begin
                    if (sync2_q) begin
                        state_d = PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        assign btn_pulse[gi] = pulse_q;
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Counter next value: opposing pulses in the same cycle cancel.
    always_comb begin
        count_d = count_q;
        unique case (btn_pulse)
            2'b01:   count_d = count_q + WIDTH'(1);
            2'b10:   count_d = count_q - WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // Counter register, wraps modulo 2^WIDTH in both directions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign up_pulse   = btn_pulse[0];
    assign down_pulse = btn_pulse[1];
    assign count_out  = count_q;

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter: directed scenarios plus random button traffic,
// all checked against a stable-run-length reference model.
module tb_button_counter;

    localparam int unsigned DC = 4;
    localparam int unsigned W  = 16;

    logic         clk;
    logic         reset_n;
    logic         btn_up;
    logic         btn_down;
    logic         up_pulse;
    logic         down_pulse;
    logic [W-1:0] count_out;

    int n_vec;
    int n_err;

    // Reference model state: raw history, accepted level, run length of
    // samples disagreeing with the accepted level, predicted pulses/count.
    logic [1:0]   m_hist [2];
    bit           m_lvl  [2];
    int           m_run  [2];
    bit           m_pls  [2];
    logic [W-1:0] m_cnt;

    int up_seen;
    int dn_seen;
    int up_last;
    int both_seen;
    int step_no;

    button_counter #(
        .DEBOUNCE_CYCLES(DC),
        .WIDTH          (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .up_pulse  (up_pulse),
        .down_pulse(down_pulse),
        .count_out (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", tag, step_no, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = 2'b00;
            m_lvl[b]  = 1'b0;
            m_run[b]  = 0;
            m_pls[b]  = 1'b0;
        end
        m_cnt = '0;
    endtask

    // One clock: advance the model at the edge, then compare on the falling edge.
    task automatic step();
        bit   raw [2];
        logic s;
        bit   np;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            raw[0] = btn_up;
            raw[1] = btn_down;
            if (m_pls[0] && !m_pls[1]) m_cnt = m_cnt + W'(1);
            else if (m_pls[1] && !m_pls[0]) m_cnt = m_cnt - W'(1);
            for (int b = 0; b < 2; b++) begin
                s  = m_hist[b][1];
                np = 1'b0;
                if (s != m_lvl[b]) m_run[b] = m_run[b] + 1;
                else m_run[b] = 0;
                if (m_run[b] == int'(DC) + 1) begin
                    m_lvl[b] = !m_lvl[b];
                    m_run[b] = 0;
                    np       = m_lvl[b];
                end
                m_pls[b]  = np;
                m_hist[b] = {m_hist[b][0], raw[b]};
            end
        end
        @(negedge clk);
        step_no++;
        check("up_pulse", 32'(up_pulse), 32'(m_pls[0]));
        check("down_pulse", 32'(down_pulse), 32'(m_pls[1]));
        check("count_out", 32'(count_out), 32'(m_cnt));
        if (up_pulse) begin
            up_seen++;
            up_last = step_no;
        end
        if (down_pulse) dn_seen++;
        if (up_pulse && down_pulse) both_seen++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        steps(2);
        reset_n = 1'b1;
        steps(1);
        up_seen   = 0;
        dn_seen   = 0;
        both_seen = 0;
        up_last   = -1;
    endtask

    task automatic press(input bit up, input bit dn, input int hold, input int rel);
        btn_up   = up;
        btn_down = dn;
        steps(hold);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        steps(rel);
    endtask

    initial begin
        int base;
        n_vec    = 0;
        n_err    = 0;
        step_no  = 0;
        reset_n  = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        model_reset();
        #2;
        check("reset_count", 32'(count_out), 32'd0);
        check("reset_up", 32'(up_pulse), 32'd0);

        // 1. Clean press: pulse only after edge DC+2, count moves at DC+3.
        do_reset();
        btn_up = 1'b1;
        base   = step_no;
        for (int i = 0; i < 20; i++) begin
            step();
            check("clean_pulse", 32'(up_pulse), 32'(i == int'(DC) + 2));
            check("clean_count", 32'(count_out), 32'(i >= int'(DC) + 3));
        end
        check("clean_npulse", 32'(up_seen), 32'd1);
        check("clean_edge", 32'(up_last - base - 1), 32'(DC + 2));
        btn_up = 1'b0;
        steps(12);

        // 2. Bounce rejection on press and a short release bounce.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            btn_up = 1'b1; steps(2);
            btn_up = 1'b0; steps(2);
        end
        btn_up = 1'b1; steps(15);
        btn_up = 1'b0; steps(2);
        btn_up = 1'b1; steps(1);
        btn_up = 1'b0; steps(14);
        check("bounce_npulse", 32'(up_seen), 32'd1);
        check("bounce_count", 32'(count_out), 32'd1);

        // 3. Wrap-around in both directions.
        do_reset();
        press(1'b0, 1'b1, 10, 12);
        check("wrap_down", 32'(count_out), 32'h0000_FFFF);
        press(1'b1, 1'b0, 10, 12);
        check("wrap_up", 32'(count_out), 32'h0000_0000);

        // 4. Simultaneous presses cancel at the counter.
        do_reset();
        press(1'b1, 1'b1, 12, 12);
        check("simul_both", 32'(both_seen), 32'd1);
        check("simul_dn", 32'(dn_seen), 32'd1);
        check("simul_count", 32'(count_out), 32'd0);

        // 5. Reset mid-debounce discards the partial press.
        do_reset();
        btn_up = 1'b1;
        steps(4);
        reset_n = 1'b0;
        steps(2);
        check("midrst_nopulse", 32'(up_seen), 32'd0);
        reset_n = 1'b1;
        base    = step_no;
        steps(20);
        check("midrst_npulse", 32'(up_seen), 32'd1);
        check("midrst_edge", 32'(up_last - base - 1), 32'(DC + 2));
        check("midrst_count", 32'(count_out), 32'd1);
        btn_up = 1'b0;
        steps(12);

        // 6. A glitch shorter than the window is ignored.
        do_reset();
        press(1'b0, 1'b1, 3, 12);
        check("glitch_npulse", 32'(dn_seen), 32'd0);
        check("glitch_count", 32'(count_out), 32'd0);

        // Random traffic, including occasional asynchronous resets.
        do_reset();
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 60) == 0) begin
                @(negedge clk);
                #2 reset_n = 1'b0;
                steps(1);
                reset_n = 1'b1;
            end
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
            steps(int'($urandom_range(1, 10)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_counter.md
Name: button_counter

Overview:
- Input-side counterpart to the LED counter output path.
- Takes two raw, asynchronous push-buttons (up and down) from the board.
- Each button is synchronized, debounced with a per-button state machine, and converted to a single-cycle press pulse.
- The pulses drive a WIDTH-bit up/down counter whose value is presented on the LEDs by the top level.
- Runs in the 10 MHz wizard clock domain. Reset comes from the wizard locked output.

Parameters:
- DEBOUNCE_CYCLES, 100000: number of consecutive stable cycles required to accept a level change (10 ms at 10 MHz). Must be ≥2.
- WIDTH, 16: counter width.

Ports:
- clk  input  1  10 MHz system clock.
- reset_n  input  1  asynchronous, active-low reset.
- btn_up  input  1  raw up button, asynchronous, active-high, bouncy.
- btn_down  input  1  raw down button, same properties as btn_up.
- up_pulse  output  1  one-cycle pulse per accepted up press.
- down_pulse  output  1  one-cycle pulse per accepted down press.
- count_out  output  WIDTH  current counter value.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Synchronizer flops, debounce counters and pulses are 0.
  - Both FSMs go to IDLE.
  - count_out is 0.
  - Reset asserted mid-debounce discards the partial press: no pulse, count unchanged at 0.
- Synchronizer: two flops per button. btn_*_s is the second-stage output. No logic reads the raw inputs directly.
- Per-button FSM: identical instance per button. Uses a cnt register of $clog2(DEBOUNCE_CYCLES) bits.
  - IDLE: if s=1 → DEB_PRESS, cnt=0.
  - DEB_PRESS:
    - if s=0 → IDLE, with no pulse.
    - else if cnt==DEBOUNCE_CYCLES-1 → PRESSED, and the registered pulse goes to 1 for exactly one cycle.
    - else cnt+1.
  - PRESSED: if s=0 → DEB_RELEASE, cnt=0. Otherwise stay; holding the button never repeats the pulse.
  - DEB_RELEASE:
    - if s=1 → PRESSED, with no pulse (release bounce).
    - else if cnt==DEBOUNCE_CYCLES-1 → IDLE.
    - else cnt+1.
- Pulse latency:
  - Edge 0 is the first clock edge sampling raw=1, and the input is stable from then on.
  - s=1 after edge 1; DEB_PRESS with cnt=0 after edge 2.
  - The pulse is high for the single cycle following edge DEBOUNCE_CYCLES+2.
  - Any raw low sampled before that returns the FSM to IDLE and restarts the window.
- Counter: updates on the edge after the pulse, so count_out changes at edge DEBOUNCE_CYCLES+3.
  - up only: +1, modulo 2^WIDTH (all-ones wraps to 0).
  - down only: −1, modulo 2^WIDTH (0 wraps to all-ones).
  - up and down pulses in the same cycle: no change.
- Outputs are all registered. There is no combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=16):
1. Clean press: reset, then hold btn_up=1 for 20 cycles.
   - up_pulse high only in the cycle after edge 6.
   - count_out goes 0→1 at edge 7.
   - No further pulses while held.
2. Bounce rejection: btn_up toggles 1,0,1,0 with each level lasting 2 cycles, then stays 1.
   - Exactly one up_pulse in total.
   - count_out=1.
   - Release bounce of 1 cycle high within the DEB_RELEASE window produces no extra pulse.
3. Wrap-around:
   - From reset, one down press → count_out=16'hFFFF.
   - Then one up press → 16'h0000.
4. Simultaneous press: drive btn_up and btn_down high on the same edge and hold.
   - up_pulse and down_pulse both pulse in the same cycle.
   - count_out unchanged at 0.
5. Reset mid-debounce: hold btn_up=1, then assert reset_n=0 at edge 4 for 2 cycles.
   - No pulse while reset is asserted.
   - After release with btn_up still high, a fresh full window elapses, giving exactly one pulse ≥7 cycles after reset release.
   - count_out=1.
6. Short glitch: btn_down=1 for 3 cycles, then 0.
   - No down_pulse.
   - count_out unchanged.
